// File: rtl/riscv_defs_pkg.sv
// Shared encodings for the MEM stage: access sizes, writeback sources, FSM states
// and the address-offset helpers used by both the request and the response path.
package riscv_defs_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  localparam logic [1:0] RD_SRC_ALU = 2'b00;
  localparam logic [1:0] RD_SRC_MEM = 2'b01;
  localparam logic [1:0] RD_SRC_PC4 = 2'b10;
  localparam logic [1:0] RD_SRC_IMM = 2'b11;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } mem_state_e;

  // Byte lane the access starts on; wider accesses drop the low address bits.
  function automatic logic [1:0] eff_offset(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      MEM_SIZE_B: eff_offset = lo;
      MEM_SIZE_H: eff_offset = {lo[1], 1'b0};
      default:    eff_offset = 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      MEM_SIZE_B: is_misaligned = 1'b0;
      MEM_SIZE_H: is_misaligned = lo[0];
      default:    is_misaligned = |lo;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load aligner: shifts the addressed lane down to bit 0 and
// sign- or zero-extends according to the access size.
module mem_load_align
  import riscv_defs_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_sign,
  output logic [31:0] o_data
);

  logic [31:0] w_shift;

  assign w_shift = i_rdata >> {i_offset, 3'b000};

  always_comb begin
    o_data = w_shift;
    case (i_size)
      MEM_SIZE_B: o_data = {{24{i_sign & w_shift[7]}}, w_shift[7:0]};
      MEM_SIZE_H: o_data = {{16{i_sign & w_shift[15]}}, w_shift[15:0]};
      default:    o_data = w_shift;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: req/gnt/rvalid data-memory port, store/load alignment and
// the MEM/WB register. Define MEM_MISALIGN_TRAP_EN to flag misaligned accesses.
module mem_stage
  import riscv_defs_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] EX_ALU_res_i,
  input  logic [4:0]      EX_rd_addr_i,
  input  logic            EX_rd_wr_en_i,
  input  logic [1:0]      EX_rd_src_i,
  input  logic [1:0]      EX_mem_op_size_i,
  input  logic            EX_mem_wr_en_i,
  input  logic            EX_Ld_sgn_i,
  input  logic [XLEN-1:0] EX_read_rs2_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            MEM_stall_o,
  output logic [4:0]      MEM_rd_addr_o,
  output logic            MEM_rd_wr_en_o,
  output logic [1:0]      MEM_rd_src_o,
  output logic [XLEN-1:0] MEM_ALU_res_o,
  output logic [XLEN-1:0] MEM_load_data_o
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic            MEM_misalign_o
`endif
);

  mem_state_e  r_state, w_state_nxt;
  logic [1:0]  r_ld_off;
  logic [1:0]  r_ld_size;
  logic        r_ld_sgn;

  logic        w_is_load, w_mem_op, w_misalign, w_access;
  logic        w_req, w_done, w_ld_cap, w_ld_done, w_act;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ld_data;

  assign w_is_load = (EX_rd_src_i == RD_SRC_MEM);
  assign w_mem_op  = EX_mem_wr_en_i | w_is_load;
  assign w_act     = ~rst_i;

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misalign = w_mem_op & is_misaligned(EX_mem_op_size_i, EX_ALU_res_i[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_access = w_mem_op & ~w_misalign;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_done      = 1'b0;
    w_ld_cap    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_access) begin
          w_req = 1'b1;
          if (dmem_gnt_i) begin
            if (EX_mem_wr_en_i) begin
              w_done = 1'b1;
            end else begin
              w_ld_cap    = 1'b1;
              w_state_nxt = WAIT_RSP;
            end
          end
        end
      end
      WAIT_RSP: begin
        if (dmem_rvalid_i) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_ld_done = (r_state == WAIT_RSP) & dmem_rvalid_i;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = EX_read_rs2_i;
    case (EX_mem_op_size_i)
      MEM_SIZE_B: begin
        w_be    = 4'b0001 << EX_ALU_res_i[1:0];
        w_wdata = {4{EX_read_rs2_i[7:0]}};
      end
      MEM_SIZE_H: begin
        w_be    = 4'b0011 << {EX_ALU_res_i[1], 1'b0};
        w_wdata = {2{EX_read_rs2_i[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = EX_read_rs2_i;
      end
    endcase
  end

  // Request-side outputs are forced quiet while reset is held.
  assign dmem_req_o   = w_req & w_act;
  assign dmem_we_o    = w_req & EX_mem_wr_en_i & w_act;
  assign dmem_be_o    = (w_req & w_act) ? w_be : 4'b0000;
  assign dmem_addr_o  = {EX_ALU_res_i[31:2], 2'b00};
  assign dmem_wdata_o = w_wdata;
  assign MEM_stall_o  = w_access & ~w_done & w_act;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ld_off  <= 2'b00;
      r_ld_size <= 2'b00;
      r_ld_sgn  <= 1'b0;
    end else if (w_ld_cap) begin
      r_ld_off  <= eff_offset(EX_mem_op_size_i, EX_ALU_res_i[1:0]);
      r_ld_size <= EX_mem_op_size_i;
      r_ld_sgn  <= EX_Ld_sgn_i;
    end
  end

  mem_load_align u_ld_align (
    .i_rdata  (dmem_rdata_i),
    .i_offset (r_ld_off),
    .i_size   (r_ld_size),
    .i_sign   (r_ld_sgn),
    .o_data   (w_ld_data)
  );

  // MEM/WB register: a stall inserts a bubble by dropping only the write enable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      MEM_rd_addr_o   <= '0;
      MEM_rd_wr_en_o  <= 1'b0;
      MEM_rd_src_o    <= '0;
      MEM_ALU_res_o   <= '0;
      MEM_load_data_o <= '0;
    end else if (MEM_stall_o) begin
      MEM_rd_wr_en_o  <= 1'b0;
    end else begin
      MEM_rd_addr_o   <= EX_rd_addr_i;
      MEM_rd_wr_en_o  <= EX_rd_wr_en_i & ~w_misalign;
      MEM_rd_src_o    <= EX_rd_src_i;
      MEM_ALU_res_o   <= EX_ALU_res_i;
      if (w_ld_done) MEM_load_data_o <= w_ld_data;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) MEM_misalign_o <= 1'b0;
    else       MEM_misalign_o <= w_misalign;
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, stores, loads with stalls,
// reset during an open load and the misaligned-word case (both builds).
module tb_mem_stage;
  import riscv_defs_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] EX_ALU_res_i;
  logic [4:0]  EX_rd_addr_i;
  logic        EX_rd_wr_en_i;
  logic [1:0]  EX_rd_src_i;
  logic [1:0]  EX_mem_op_size_i;
  logic        EX_mem_wr_en_i;
  logic        EX_Ld_sgn_i;
  logic [31:0] EX_read_rs2_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        MEM_stall_o;
  logic [4:0]  MEM_rd_addr_o;
  logic        MEM_rd_wr_en_o;
  logic [1:0]  MEM_rd_src_o;
  logic [31:0] MEM_ALU_res_o, MEM_load_data_o;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        MEM_misalign_o;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  mem_stage dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .EX_ALU_res_i(EX_ALU_res_i), .EX_rd_addr_i(EX_rd_addr_i),
    .EX_rd_wr_en_i(EX_rd_wr_en_i), .EX_rd_src_i(EX_rd_src_i),
    .EX_mem_op_size_i(EX_mem_op_size_i), .EX_mem_wr_en_i(EX_mem_wr_en_i),
    .EX_Ld_sgn_i(EX_Ld_sgn_i), .EX_read_rs2_i(EX_read_rs2_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .MEM_stall_o(MEM_stall_o), .MEM_rd_addr_o(MEM_rd_addr_o),
    .MEM_rd_wr_en_o(MEM_rd_wr_en_o), .MEM_rd_src_o(MEM_rd_src_o),
    .MEM_ALU_res_o(MEM_ALU_res_o), .MEM_load_data_o(MEM_load_data_o)
`ifdef MEM_MISALIGN_TRAP_EN
    , .MEM_misalign_o(MEM_misalign_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_ex();
    EX_ALU_res_i     = '0;
    EX_rd_addr_i     = '0;
    EX_rd_wr_en_i    = 1'b0;
    EX_rd_src_i      = RD_SRC_ALU;
    EX_mem_op_size_i = MEM_SIZE_W;
    EX_mem_wr_en_i   = 1'b0;
    EX_Ld_sgn_i      = 1'b0;
    EX_read_rs2_i    = '0;
    dmem_gnt_i       = 1'b0;
    dmem_rvalid_i    = 1'b0;
    dmem_rdata_i     = '0;
  endtask

  task automatic set_load(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                          input logic [4:0] rd);
    EX_ALU_res_i     = addr;
    EX_rd_addr_i     = rd;
    EX_rd_wr_en_i    = 1'b1;
    EX_rd_src_i      = RD_SRC_MEM;
    EX_mem_op_size_i = size;
    EX_mem_wr_en_i   = 1'b0;
    EX_Ld_sgn_i      = sgn;
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] rs2, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata);
    EX_ALU_res_i     = addr;
    EX_rd_src_i      = RD_SRC_ALU;
    EX_mem_op_size_i = size;
    EX_mem_wr_en_i   = 1'b1;
    EX_read_rs2_i    = rs2;
    dmem_gnt_i       = 1'b1;
    #1;
    chk({tag, "_req"},   {31'd0, dmem_req_o}, 32'd1);
    chk({tag, "_we"},    {31'd0, dmem_we_o}, 32'd1);
    chk({tag, "_be"},    {28'd0, dmem_be_o}, {28'd0, exp_be});
    chk({tag, "_wdata"}, dmem_wdata_o, exp_wdata);
    chk({tag, "_addr"},  dmem_addr_o, {addr[31:2], 2'b00});
    chk({tag, "_stall"}, {31'd0, MEM_stall_o}, 32'd0);
    tick();
    clr_ex();
  endtask

  // Load granted immediately, response one cycle later.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] rdata, input logic [31:0] exp);
    set_load(addr, size, sgn, 5'd9);
    dmem_gnt_i = 1'b1;
    #1;
    chk({tag, "_req"},   {31'd0, dmem_req_o}, 32'd1);
    chk({tag, "_stall"}, {31'd0, MEM_stall_o}, 32'd1);
    tick();
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = rdata;
    #1;
    chk({tag, "_req_wait"}, {31'd0, dmem_req_o}, 32'd0);
    tick();
    clr_ex();
    chk({tag, "_data"},  MEM_load_data_o, exp);
    chk({tag, "_wr_en"}, {31'd0, MEM_rd_wr_en_o}, 32'd1);
  endtask

  initial begin
    clr_ex();
    rst_i = 1'b1;
    repeat (2) tick();
    chk("rst_wr_en",  {31'd0, MEM_rd_wr_en_o}, 32'd0);
    chk("rst_alu",    MEM_ALU_res_o, 32'd0);
    chk("rst_ldata",  MEM_load_data_o, 32'd0);
    chk("rst_req",    {31'd0, dmem_req_o}, 32'd0);
    rst_i = 1'b0;
    tick();

    // ALU op passes through in one cycle without touching memory
    EX_ALU_res_i  = 32'h1234;
    EX_rd_addr_i  = 5'd5;
    EX_rd_wr_en_i = 1'b1;
    #1;
    chk("alu_req",   {31'd0, dmem_req_o}, 32'd0);
    chk("alu_stall", {31'd0, MEM_stall_o}, 32'd0);
    tick();
    clr_ex();
    chk("alu_res",   MEM_ALU_res_o, 32'h1234);
    chk("alu_wr_en", {31'd0, MEM_rd_wr_en_o}, 32'd1);
    chk("alu_rd",    {27'd0, MEM_rd_addr_o}, 32'd5);

    do_store("sb", 32'h103, MEM_SIZE_B, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB);
    do_store("sh", 32'h102, MEM_SIZE_H, 32'h1234_5678, 4'b1100, 32'h5678_5678);
    do_store("sw", 32'h104, MEM_SIZE_W, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

    // lb signed with gnt delayed two cycles
    set_load(32'h102, MEM_SIZE_B, 1'b1, 5'd7);
    #1;
    chk("lb_stall0", {31'd0, MEM_stall_o}, 32'd1);
    chk("lb_req0",   {31'd0, dmem_req_o}, 32'd1);
    chk("lb_we0",    {31'd0, dmem_we_o}, 32'd0);
    tick();
    chk("lb_stall1",  {31'd0, MEM_stall_o}, 32'd1);
    chk("lb_bubble",  {31'd0, MEM_rd_wr_en_o}, 32'd0);
    tick();
    dmem_gnt_i = 1'b1;
    #1;
    chk("lb_stall2", {31'd0, MEM_stall_o}, 32'd1);
    chk("lb_req2",   {31'd0, dmem_req_o}, 32'd1);
    tick();
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h0080_0000;
    #1;
    chk("lb_stall3", {31'd0, MEM_stall_o}, 32'd0);
    chk("lb_req3",   {31'd0, dmem_req_o}, 32'd0);
    tick();
    clr_ex();
    chk("lb_data",  MEM_load_data_o, 32'hFFFF_FF80);
    chk("lb_wr_en", {31'd0, MEM_rd_wr_en_o}, 32'd1);
    chk("lb_rd",    {27'd0, MEM_rd_addr_o}, 32'd7);

    do_load("lhu", 32'h2,   MEM_SIZE_H, 1'b0, 32'hBEEF_0000, 32'h0000_BEEF);
    do_load("lw",  32'h200, MEM_SIZE_W, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_load("lbu", 32'h3,   MEM_SIZE_B, 1'b0, 32'h8000_0000, 32'h0000_0080);
    do_load("lh",  32'h0,   MEM_SIZE_H, 1'b1, 32'h1234_8001, 32'hFFFF_8001);
    do_load("lb+", 32'h1,   MEM_SIZE_B, 1'b1, 32'h0000_7F00, 32'h0000_007F);

    // reset while a load is outstanding
    set_load(32'h40, MEM_SIZE_W, 1'b0, 5'd3);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    rst_i = 1'b1;
    #1;
    chk("mrst_stall", {31'd0, MEM_stall_o}, 32'd0);
    chk("mrst_req",   {31'd0, dmem_req_o}, 32'd0);
    chk("mrst_be",    {28'd0, dmem_be_o}, 32'd0);
    chk("mrst_alu",   MEM_ALU_res_o, 32'd0);
    chk("mrst_ldata", MEM_load_data_o, 32'd0);
    tick();
    rst_i = 1'b0;
    #1;
    // back in IDLE: the held load request is issued again
    chk("mrst_idle_req", {31'd0, dmem_req_o}, 32'd1);
    tick();
    clr_ex();
    tick();

    // sw to a misaligned address
    EX_ALU_res_i     = 32'h102;
    EX_mem_op_size_i = MEM_SIZE_W;
    EX_mem_wr_en_i   = 1'b1;
    EX_read_rs2_i    = 32'h1111_2222;
    dmem_gnt_i       = 1'b1;
    #1;
`ifdef MEM_MISALIGN_TRAP_EN
    chk("mis_req",   {31'd0, dmem_req_o}, 32'd0);
    chk("mis_stall", {31'd0, MEM_stall_o}, 32'd0);
    tick();
    clr_ex();
    chk("mis_flag",  {31'd0, MEM_misalign_o}, 32'd1);
    chk("mis_wr_en", {31'd0, MEM_rd_wr_en_o}, 32'd0);
    tick();
    chk("mis_flag_clr", {31'd0, MEM_misalign_o}, 32'd0);
`else
    chk("mis_req",  {31'd0, dmem_req_o}, 32'd1);
    chk("mis_be",   {28'd0, dmem_be_o}, 32'hF);
    chk("mis_addr", dmem_addr_o, 32'h100);
    tick();
    clr_ex();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
